// File: rtl/cic_pkg.sv
// Shared types and helpers for the time-shared I/Q CIC decimator.
package cic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMB_I = 2'd1,
    COMB_Q = 2'd2,
    OUT    = 2'd3
  } state_t;

  function automatic int unsigned cic_accw(input int unsigned in_w, input int unsigned n,
                                           input int unsigned r);
    return in_w + n * $clog2(r);
  endfunction

  // y is an accw-bit value sign-extended to 64 bits; result is ow bits sign-extended.
  function automatic logic signed [63:0] scale_out(input logic signed [63:0] y,
                                                   input int unsigned accw,
                                                   input int unsigned ow,
                                                   input bit rnd);
    longint v;
    longint vmax;
    v    = y;
    vmax = (longint'(1) <<< (ow - 1)) - longint'(1);
    if (accw > ow) begin
      if (rnd) begin
        v = v + (longint'(1) <<< (accw - ow - 1));
      end
      v = v >>> (accw - ow);
      // Only the positive rail can overflow after adding the half-LSB.
      if (rnd && (v > vmax)) begin
        v = vmax;
      end
    end else begin
      v = v <<< (ow - accw);
    end
    return v;
  endfunction

endpackage

// File: rtl/cic_decim_iq_integ.sv
// N-stage pipelined integrator chain for one rail, modular ACCW-bit arithmetic.
module cic_integ_chain #(
  parameter int unsigned IN_WIDTH = 18,
  parameter int unsigned ACCW     = 28,
  parameter int unsigned N        = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       en_i,
  input  logic signed [IN_WIDTH-1:0] din_i,
  output logic        [ACCW-1:0]     dout_o
);

  logic [ACCW-1:0] stage_q [N];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < int'(N); k++) stage_q[k] <= '0;
    end else if (en_i) begin
      stage_q[0] <= stage_q[0] + ACCW'(din_i);
      for (int k = 1; k < int'(N); k++) stage_q[k] <= stage_q[k] + stage_q[k-1];
    end
  end

  assign dout_o = stage_q[N-1];

endmodule

// File: rtl/cic_decim_iq.sv
// Time-shared I/Q CIC decimator: parallel integrators, serial comb (I then Q).
// Define CIC_ROUND_EN for round-half-up with saturation at the output slice.
import cic_pkg::*;

module cic_decim_iq #(
  parameter int unsigned IN_WIDTH  = 18,
  parameter int unsigned OUT_WIDTH = 24,
  parameter int unsigned N         = 5,
  parameter int unsigned R         = 3
) (
  input  logic                        adc_clk,
  input  logic                        reset_n,
  input  logic                        in_strobe,
  input  logic signed [IN_WIDTH-1:0]  in_data_i,
  input  logic signed [IN_WIDTH-1:0]  in_data_q,
  output logic                        out_strobe,
  output logic signed [OUT_WIDTH-1:0] out_data_i,
  output logic signed [OUT_WIDTH-1:0] out_data_q,
  output logic                        overrun
);

  localparam int unsigned ACCW = cic_accw(IN_WIDTH, N, R);
  localparam int unsigned DW   = $clog2(R);
  localparam int unsigned SW   = (N > 1) ? $clog2(N) : 1;
`ifdef CIC_ROUND_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

  logic [ACCW-1:0] integ_i, integ_q;

  cic_integ_chain #(.IN_WIDTH(IN_WIDTH), .ACCW(ACCW), .N(N)) u_integ_i (
    .clk_i(adc_clk), .rst_n_i(reset_n), .en_i(in_strobe), .din_i(in_data_i), .dout_o(integ_i)
  );
  cic_integ_chain #(.IN_WIDTH(IN_WIDTH), .ACCW(ACCW), .N(N)) u_integ_q (
    .clk_i(adc_clk), .rst_n_i(reset_n), .en_i(in_strobe), .din_i(in_data_q), .dout_o(integ_q)
  );

  state_t                        state_q, state_d;
  logic        [DW-1:0]          dcnt_q, dcnt_d;
  logic                          ev_q, ev_d;
  logic        [SW-1:0]          s_q, s_d;
  logic signed [ACCW-1:0]        acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [ACCW-1:0]        dly_i_q [N];
  logic signed [ACCW-1:0]        dly_i_d [N];
  logic signed [ACCW-1:0]        dly_q_q [N];
  logic signed [ACCW-1:0]        dly_q_d [N];
  logic                          out_strobe_q, out_strobe_d;
  logic signed [OUT_WIDTH-1:0]   out_i_q, out_i_d, out_q_q, out_q_d;
  logic                          overrun_q, overrun_d;
  logic signed [ACCW-1:0]        diff_i, diff_q;
  logic                          last_stage;

  always_ff @(posedge adc_clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      dcnt_q       <= '0;
      ev_q         <= 1'b0;
      s_q          <= '0;
      acc_i_q      <= '0;
      acc_q_q      <= '0;
      for (int k = 0; k < int'(N); k++) begin
        dly_i_q[k] <= '0;
        dly_q_q[k] <= '0;
      end
      out_strobe_q <= 1'b0;
      out_i_q      <= '0;
      out_q_q      <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      dcnt_q       <= dcnt_d;
      ev_q         <= ev_d;
      s_q          <= s_d;
      acc_i_q      <= acc_i_d;
      acc_q_q      <= acc_q_d;
      dly_i_q      <= dly_i_d;
      dly_q_q      <= dly_q_d;
      out_strobe_q <= out_strobe_d;
      out_i_q      <= out_i_d;
      out_q_q      <= out_q_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    ev_d         = 1'b0;
    s_d          = s_q;
    acc_i_d      = acc_i_q;
    acc_q_d      = acc_q_q;
    dly_i_d      = dly_i_q;
    dly_q_d      = dly_q_q;
    out_strobe_d = 1'b0;
    out_i_d      = out_i_q;
    out_q_d      = out_q_q;
    overrun_d    = overrun_q;
    diff_i       = acc_i_q - dly_i_q[s_q];
    diff_q       = acc_q_q - dly_q_q[s_q];
    last_stage   = (s_q == SW'(N - 1));

    if (in_strobe) begin
      ev_d   = (dcnt_q == DW'(R - 1));
      dcnt_d = ev_d ? '0 : dcnt_q + DW'(1);
    end

    // An event seen while the comb is busy is dropped, never queued.
    if (ev_q && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (ev_q) begin
          state_d = COMB_I;
          s_d     = '0;
          acc_i_d = signed'(integ_i);
          acc_q_d = signed'(integ_q);
        end
      end
      COMB_I: begin
        acc_i_d        = diff_i;
        dly_i_d[s_q]   = acc_i_q;
        s_d            = last_stage ? '0 : s_q + SW'(1);
        if (last_stage) state_d = COMB_Q;
      end
      COMB_Q: begin
        acc_q_d        = diff_q;
        dly_q_d[s_q]   = acc_q_q;
        s_d            = last_stage ? '0 : s_q + SW'(1);
        // Final Q difference is scaled straight off the subtractor so the pair lands in OUT.
        if (last_stage) begin
          state_d      = OUT;
          out_strobe_d = 1'b1;
          out_i_d      = OUT_WIDTH'(scale_out(64'(acc_i_q), ACCW, OUT_WIDTH, RoundEn));
          out_q_d      = OUT_WIDTH'(scale_out(64'(diff_q), ACCW, OUT_WIDTH, RoundEn));
        end
      end
      OUT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_strobe = out_strobe_q;
  assign out_data_i = out_i_q;
  assign out_data_q = out_q_q;
  assign overrun    = overrun_q;

endmodule
